// File: rtl/fft_pkg.sv
// Shared types, constants and twiddle ROM for the 64-point iterative radix-2 DIT FFT.
package fft_pkg;

  localparam int N      = 64;
  localparam int LOG2N  = 6;
  localparam int DATA_W = 16;
  localparam int TW_W   = 16;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // cos/sin(2*pi*k/64) for k = 0..31 in Q2.14, rounded to nearest
  localparam logic signed [TW_W-1:0] TW_COS [N/2] = '{
    16'sd16384,  16'sd16305,  16'sd16069,  16'sd15679,  16'sd15137,  16'sd14449,  16'sd13623,  16'sd12665,
    16'sd11585,  16'sd10394,  16'sd9102,   16'sd7723,   16'sd6270,   16'sd4756,   16'sd3196,   16'sd1606,
    16'sd0,     -16'sd1606,  -16'sd3196,  -16'sd4756,  -16'sd6270,  -16'sd7723,  -16'sd9102,  -16'sd10394,
   -16'sd11585, -16'sd12665, -16'sd13623, -16'sd14449, -16'sd15137, -16'sd15679, -16'sd16069, -16'sd16305
  };

  localparam logic signed [TW_W-1:0] TW_SIN [N/2] = '{
    16'sd0,      16'sd1606,   16'sd3196,   16'sd4756,   16'sd6270,   16'sd7723,   16'sd9102,   16'sd10394,
    16'sd11585,  16'sd12665,  16'sd13623,  16'sd14449,  16'sd15137,  16'sd15679,  16'sd16069,  16'sd16305,
    16'sd16384,  16'sd16305,  16'sd16069,  16'sd15679,  16'sd15137,  16'sd14449,  16'sd13623,  16'sd12665,
    16'sd11585,  16'sd10394,  16'sd9102,   16'sd7723,   16'sd6270,   16'sd4756,   16'sd3196,   16'sd1606
  };

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] n);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = n[LOG2N-1-i];
    return r;
  endfunction

  // Q2.14 product back to integer scale, rounded half up
  function automatic logic signed [DATA_W+1:0] round_q14(input logic signed [31:0] p);
    return 18'((p + 32'sd8192) >>> 14);
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 butterfly: t = b*w with per-product rounding, outputs (a +/- t)/2 floored.
module fft_butterfly
  import fft_pkg::*;
(
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  output logic signed [DATA_W-1:0] top_re,
  output logic signed [DATA_W-1:0] top_im,
  output logic signed [DATA_W-1:0] bot_re,
  output logic signed [DATA_W-1:0] bot_im
);

  logic signed [31:0]       p_rr, p_ii, p_ri, p_ir;
  logic signed [DATA_W+1:0] t_re, t_im;
  logic signed [DATA_W+1:0] s_top_re, s_top_im, s_bot_re, s_bot_im;

  assign p_rr = 32'(b_re) * 32'(w_re);
  assign p_ii = 32'(b_im) * 32'(w_im);
  assign p_ri = 32'(b_re) * 32'(w_im);
  assign p_ir = 32'(b_im) * 32'(w_re);

  assign t_re = round_q14(p_rr) - round_q14(p_ii);
  assign t_im = round_q14(p_ri) + round_q14(p_ir);

  // Sums carry two guard bits so a full-scale twiddled operand cannot wrap before halving
  assign s_top_re = 18'(a_re) + t_re;
  assign s_top_im = 18'(a_im) + t_im;
  assign s_bot_re = 18'(a_re) - t_re;
  assign s_bot_im = 18'(a_im) - t_im;

  assign top_re = 16'(s_top_re >>> 1);
  assign top_im = 16'(s_top_im >>> 1);
  assign bot_re = 16'(s_bot_re >>> 1);
  assign bot_im = 16'(s_bot_im >>> 1);

endmodule

// File: rtl/fft.sv
// 64-point iterative DIT FFT, one butterfly per clock, 1/2 scaling per stage.
// Define IFFT_EN to add the `ifft` port selecting the conjugate twiddle (inverse transform).
module fft
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] input_Re  [N],
  input  logic [DATA_W-1:0] input_Im  [N],
  input  logic              start,
`ifdef IFFT_EN
  input  logic              ifft,
`endif
  output logic [DATA_W-1:0] output_Re [N],
  output logic [DATA_W-1:0] output_Im [N],
  output logic              busy,
  output logic              done
);

  state_t                   state;
  logic [2:0]               stage;
  logic [4:0]               bfly;
  cplx_t                    mem [N];
  logic [4:0]               low, tw_idx;
  logic [5:0]               span, top_addr, bot_addr;
  logic signed [TW_W-1:0]   w_re, w_im;
  logic signed [DATA_W-1:0] top_re, top_im, bot_re, bot_im;

  // Butterfly address generation; the 5-bit mask wraps to all-ones in the last stage
  assign low      = bfly & ((5'd1 << stage) - 5'd1);
  assign span     = 6'd1 << stage;
  assign top_addr = (({1'b0, bfly} >> stage) << (stage + 3'd1)) | {1'b0, low};
  assign bot_addr = top_addr | span;
  assign tw_idx   = low << (3'd5 - stage);

  assign w_re = TW_COS[tw_idx];
`ifdef IFFT_EN
  logic ifft_q;
  assign w_im = ifft_q ? TW_SIN[tw_idx] : -TW_SIN[tw_idx];
`else
  assign w_im = -TW_SIN[tw_idx];
`endif

  fft_butterfly u_bfly (
    .a_re   (mem[top_addr].re),
    .a_im   (mem[top_addr].im),
    .b_re   (mem[bot_addr].re),
    .b_im   (mem[bot_addr].im),
    .w_re   (w_re),
    .w_im   (w_im),
    .top_re (top_re),
    .top_im (top_im),
    .bot_re (bot_re),
    .bot_im (bot_im)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      stage <= '0;
      bfly  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef IFFT_EN
      ifft_q <= 1'b0;
`endif
      // NOTE: the working array is plain flops and is cleared here too, so an aborted frame leaves no residue.
      for (int i = 0; i < N; i++) begin
        mem[i]       <= '0;
        output_Re[i] <= '0;
        output_Im[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int n = 0; n < N; n++) begin
              mem[bit_rev(6'(n))] <= {input_Re[n], input_Im[n]};
            end
`ifdef IFFT_EN
            ifft_q <= ifft;
`endif
            stage <= '0;
            bfly  <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          // NOTE: non-blocking writes make both in-place results use the operands read before this edge.
          mem[top_addr] <= {top_re, top_im};
          mem[bot_addr] <= {bot_re, bot_im};
          if (bfly == 5'd31) begin
            bfly <= '0;
            if (stage == 3'(LOG2N - 1)) state <= DONE;
            else                        stage <= stage + 3'd1;
          end else begin
            bfly <= bfly + 5'd1;
          end
        end
        DONE: begin
          for (int i = 0; i < N; i++) begin
            output_Re[i] <= mem[i].re;
            output_Im[i] <= mem[i].im;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft.sv
// Directed bench for fft: real-valued DFT reference feeds a scoreboard checked at each done pulse.
module tb_fft;
  import fft_pkg::*;

  localparam real PI = 3.14159265358979323846;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] input_Re  [N];
  logic [DATA_W-1:0] input_Im  [N];
  logic [DATA_W-1:0] output_Re [N];
  logic [DATA_W-1:0] output_Im [N];
  logic              busy;
  logic              done;

  int n_assert = 0;
  int n_fail   = 0;
  int fr_re [N];
  int fr_im [N];
  int snap_re [N];
  int snap_im [N];
  int exp_q [$];
  int tol_q [$];

  fft dut (
    .clk       (clk),
    .rst       (rst),
    .input_Re  (input_Re),
    .input_Im  (input_Im),
    .start     (start),
`ifdef IFFT_EN
    .ifft      (1'b0),
`endif
    .output_Re (output_Re),
    .output_Im (output_Im),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v, input int tol);
    n_assert++;
    assert (((obs >= exp_v - tol) && (obs <= exp_v + tol)) === 1'b1)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp_v, tol);
      end
  endtask

  function automatic int out_re(input int k);
    return int'($signed(output_Re[k]));
  endfunction

  function automatic int out_im(input int k);
    return int'($signed(output_Im[k]));
  endfunction

  task automatic clear_frame();
    for (int n = 0; n < N; n++) begin
      fr_re[n] = 0;
      fr_im[n] = 0;
    end
  endtask

  task automatic random_frame();
    for (int n = 0; n < N; n++) begin
      fr_re[n] = int'($urandom_range(4000, 0)) - 2000;
      fr_im[n] = int'($urandom_range(4000, 0)) - 2000;
    end
  endtask

  // Forward DFT / 64, rounded to nearest, pushed as 64 Re then 64 Im
  task automatic push_expected(input int tol);
    int er [N];
    int ei [N];
    for (int k = 0; k < N; k++) begin
      real sr, si, ang;
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < N; n++) begin
        ang = 2.0 * PI * real'((n * k) % N) / real'(N);
        sr += real'(fr_re[n]) * $cos(ang) + real'(fr_im[n]) * $sin(ang);
        si += real'(fr_im[n]) * $cos(ang) - real'(fr_re[n]) * $sin(ang);
      end
      er[k] = int'(sr / real'(N));
      ei[k] = int'(si / real'(N));
    end
    for (int k = 0; k < N; k++) begin exp_q.push_back(er[k]); tol_q.push_back(tol); end
    for (int k = 0; k < N; k++) begin exp_q.push_back(ei[k]); tol_q.push_back(tol); end
  endtask

  task automatic drive_frame(input bit push, input int tol);
    for (int n = 0; n < N; n++) begin
      input_Re[n] = 16'(fr_re[n]);
      input_Im[n] = 16'(fr_im[n]);
    end
    if (push) push_expected(tol);
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_sb_depth"}, exp_q.size() >= 2 * N ? 2 * N : exp_q.size(), 2 * N, 0);
    if (exp_q.size() >= 2 * N) begin
      for (int k = 0; k < N; k++)
        check($sformatf("%s_re%0d", tag, k), out_re(k), exp_q.pop_front(), tol_q.pop_front());
      for (int k = 0; k < N; k++)
        check($sformatf("%s_im%0d", tag, k), out_im(k), exp_q.pop_front(), tol_q.pop_front());
    end
  endtask

  // Called #1 after a clock edge; returns edges elapsed until done is seen (bounded)
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 400) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic count_zero_outputs(output int nonzero);
    nonzero = 0;
    for (int k = 0; k < N; k++) begin
      if (output_Re[k] !== '0) nonzero++;
      if (output_Im[k] !== '0) nonzero++;
    end
  endtask

  task automatic single_frame(input string tag);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy"}, int'(busy), 1, 0);
    wait_done(cyc);
    check({tag, "_latency"}, cyc, 193, 0);
    compare_frame(tag);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, int'(done), 0, 0);
    check({tag, "_busy_after"}, int'(busy), 0, 0);
  endtask

  initial begin
    int cyc, nz, pulses, diffs;

    rst   = 1'b1;
    start = 1'b0;
    clear_frame();
    drive_frame(1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    count_zero_outputs(nz);
    check("reset_outputs", nz, 0, 0);
    check("reset_busy", int'(busy), 0, 0);
    check("reset_done", int'(done), 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle with no start: done must never pulse
    pulses = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("idle_no_done", pulses, 0, 0);
    count_zero_outputs(nz);
    check("idle_outputs", nz, 0, 0);

    // Half-length rectangle
    clear_frame();
    for (int n = 0; n < 32; n++) fr_re[n] = 32;
    drive_frame(1'b1, 3);
    single_frame("ramp");
    check("ramp_re0", out_re(0), 16, 0);
    check("ramp_im0", out_im(0), 0, 0);
    check("ramp_im1", out_im(1), -10, 2);
    check("ramp_im63", out_im(63), 10, 2);
    for (int k = 2; k < N; k += 2) begin
      check($sformatf("ramp_even_re%0d", k), out_re(k), 0, 2);
      check($sformatf("ramp_even_im%0d", k), out_im(k), 0, 2);
    end

    // Impulse: flat spectrum, exact
    clear_frame();
    fr_re[0] = 1024;
    drive_frame(1'b1, 0);
    single_frame("impulse");

    // DC of -512
    for (int n = 0; n < N; n++) fr_re[n] = -512;
    drive_frame(1'b1, 1);
    single_frame("dc");

    // Abort 100 cycles into CALC; no expectation is pushed for this frame
    random_frame();
    drive_frame(1'b0, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    count_zero_outputs(nz);
    check("abort_outputs", nz, 0, 0);
    check("abort_busy", int'(busy), 0, 0);
    check("abort_done", int'(done), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (250) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0, 0);

    random_frame();
    drive_frame(1'b1, 4);
    single_frame("post_abort");

    // Back-to-back: start held high; inputs change right after the first capture
    clear_frame();
    fr_re[5] = 640;
    fr_im[5] = -320;
    drive_frame(1'b1, 3);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    random_frame();
    drive_frame(1'b1, 4);
    wait_done(cyc);
    check("b2b_a_latency", cyc, 193, 0);
    compare_frame("b2b_a");
    for (int k = 0; k < N; k++) begin
      snap_re[k] = out_re(k);
      snap_im[k] = out_im(k);
    end
    // The next capture is the edge right after DONE: 1 + 192 + 1 edges between pulses
    diffs = 0;
    cyc   = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (!done)
        for (int k = 0; k < N; k++)
          if (out_re(k) != snap_re[k] || out_im(k) != snap_im[k]) diffs++;
    end while (!done && cyc < 400);
    start = 1'b0;
    check("b2b_period", cyc, 194, 0);
    check("b2b_hold", diffs, 0, 0);
    compare_frame("b2b_b");
    @(posedge clk);
    #1;
    check("b2b_stop_busy", int'(busy), 0, 0);
    check("b2b_stop_done", int'(done), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
